mux16_rr_arbiter: RTL
=====================

Name: mux16_rr_arbiter

Overview:
- Sequential round-robin arbiter that shares one 16:1 datapath mux (one shared resource, e.g. a write/result bus) among 16 requesters.
- Grants one requester at a time and drives the 4-bit mux select.
- Holds ownership until the owner signals done, drops its request, or a hold timeout expires.
- Sits beside the shared mux in the pipeline; its sel output feeds the mux sel input directly.

Parameters:
- N_REQ, 16, number of requesters; fixed at 16 to match the 4-bit select.
- SEL_W, 4, select width; log2(N_REQ).
- MAX_HOLD, 64, maximum cycles one owner may hold the grant before forced release. Range 2..65535.
- CNT_W, 16, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  16  request vector; bit i high means requester i wants the resource.
- done  input  1  owner pulse; transfer complete, release the grant.
- grant  output  16  one-hot grant; all zero when idle.
- sel  output  4  binary index of the current owner; drives the shared mux sel.
- busy  output  1  high while some requester owns the resource.
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Behaviour:
- Interface decided: one clock (clk); reset rst_n is asynchronous and active-low. Every register clears immediately on rst_n low, independent of clk.
- Reset values:
  - grant = 0, sel = 0, busy = 0, timeout = 0.
  - Round-robin pointer ptr = 0; hold counter = 0; state = IDLE.
- State machine, two states, registered:
  - IDLE: if req != 0, winner = first set bit of req searching upward from ptr, wrapping 15 -> 0. Next cycle: state = BUSY, grant = onehot(winner), sel = winner, busy = 1, counter = 0. If req == 0, stay in IDLE.
  - BUSY: grant, sel and busy are held stable, and counter increments each cycle. The grant is released when any of these is true:
    - (a) done = 1;
    - (b) req[sel] = 0 (requester aborted);
    - (c) counter == MAX_HOLD-1.
  - On release, next cycle: state = IDLE, grant = 0, busy = 0, ptr = (sel+1) mod 16. sel retains its last value.
  - timeout = 1 for exactly that one cycle, and only when (c) is the sole release cause.
- Latency:
  - req seen in IDLE at cycle N -> grant valid at N+1.
  - Release condition at cycle M -> grant = 0 at M+1; the earliest next grant is M+2.
  - There is one dead cycle between owners by design, so the mux input switches glitch-free relative to the bus.
- Fairness: after requester k is served, k has the lowest priority in the next arbitration. Any continuously requesting requester is granted within 15 ownership periods.
- done received while in IDLE is ignored.
- done and timeout in the same cycle: treated as a normal done release, timeout stays 0.
- Request changes during BUSY from non-owners have no effect until the next IDLE cycle.
- sel is always binary-consistent with grant whenever busy = 1.
- Counter width: CNT_W bits, saturating is unnecessary because the counter is reset on every grant.
- Reset mid-ownership: asynchronous clear to the reset values above; ptr returns to 0.

Decomposition:
- Shared package (header) holds:
  - N_REQ = 16 and SEL_W = 4;
  - state encodings ST_IDLE = 1'b0 and ST_BUSY = 1'b1;
  - default MAX_HOLD.
- One natural combinational sub-module, rr_pick16:
  - inputs req[15:0] and ptr[3:0];
  - outputs found (1 bit) and idx[3:0], the rotating priority search.
- The top module holds the FSM, ptr, counter and output registers.

Test Plan:
- Reset/idle: hold rst_n = 0, drive req = 16'hFFFF -> grant = 0, sel = 0, busy = 0. Release reset with req = 0 -> outputs stay 0.
- Single requester: req = 16'h0020 at cycle N -> grant = 16'h0020, sel = 5, busy = 1 at N+1. done at N+4 -> grant = 0 at N+5, ptr = 6.
- Round-robin rotation: req = 16'h8101 held, done pulsed every third cycle -> grant sequence sel = 0, 8, 15, 0, 8, with one idle cycle between owners.
- Wrap-around: ptr = 15 (after serving 14), req = 16'h4001 -> the next winner is sel = 0, not 14.
- Timeout: MAX_HOLD = 4, req = 16'h0004 held, no done -> busy for exactly 4 cycles. timeout pulses 1 cycle with grant = 0, then requester 2 is regranted 1 cycle later.
- Abort and async reset:
  - Owner 3 drops req[3] mid-BUSY -> grant = 0 next cycle, timeout = 0.
  - Assert rst_n low between clock edges while busy -> grant, busy and sel clear immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/mux16_rr_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mux16_rr_arbiter_pkg
// Shared constants and types for the 16-way round-robin arbiter that drives
// the select of a shared 16:1 datapath mux.
//   N_REQ        : number of requesters (fixed to match the 4-bit select)
//   SEL_W        : width of the binary mux select
//   MAX_HOLD_DEF : default maximum ownership length in cycles
//   state_e      : arbiter FSM state encoding
// ----------------------------------------------------------------------------
package mux16_rr_arbiter_pkg;

    localparam int N_REQ        = 16;
    localparam int SEL_W        = 4;
    localparam int MAX_HOLD_DEF = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

endpackage : mux16_rr_arbiter_pkg

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// ----------------------------------------------------------------------------
// rr_pick16
// Combinational rotating-priority search over 16 request lines.
// The search starts at index ptr and moves upward, wrapping 15 -> 0; the
// first set request found is the winner.
// Ports:
//   req   [15:0] in  : request vector
//   ptr   [3:0]  in  : highest-priority index for this search
//   found        out : at least one request is set
//   idx   [3:0]  out : winning requester index (0 when nothing is found)
// ----------------------------------------------------------------------------
module rr_pick16
    import mux16_rr_arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set request
    // (the highest priority one) is the last to write idx. The 4-bit add
    // gives the 15 -> 0 wrap for free.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule : rr_pick16

// File: rtl/mux16_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux16_rr_arbiter
// Round-robin arbiter sharing one 16:1 datapath mux among 16 requesters.
// One owner at a time; ownership ends on done, on the owner dropping its
// request, or when the hold counter reaches MAX_HOLD-1. A single idle cycle
// always separates two owners so the mux select never changes under a
// live transfer.
// Parameters:
//   MAX_HOLD : maximum ownership length in cycles (2..65535)
//   CNT_W    : hold counter width, 2^CNT_W > MAX_HOLD
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   req   [15:0] in  : request vector
//   done         in  : owner's transfer-complete pulse
//   grant [15:0] out : one-hot grant, zero when idle
//   sel   [3:0]  out : binary owner index, feeds the shared mux select
//   busy         out : a requester currently owns the resource
//   timeout      out : one-cycle pulse on a forced MAX_HOLD release
// ----------------------------------------------------------------------------
module mux16_rr_arbiter
    import mux16_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             timeout
);

    state_e           state_q,   state_d;
    logic [SEL_W-1:0] ptr_q,     ptr_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [N_REQ-1:0] grant_q,   grant_d;
    logic [SEL_W-1:0] sel_q,     sel_d;
    logic             busy_q,    busy_d;
    logic             timeout_q, timeout_d;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             hold_hit;
    logic             owner_req;

    rr_pick16 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        hold_hit  = (cnt_q == CNT_W'(MAX_HOLD - 1));
        owner_req = req[sel_q];

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BUSY;
                    grant_d = {{(N_REQ - 1){1'b0}}, 1'b1} << pick_idx;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (done || !owner_req || hold_hit) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    // Owner drops to lowest priority; sel keeps its value.
                    ptr_d     = sel_q + SEL_W'(1);
                    // Flag only releases forced purely by the hold limit.
                    timeout_d = hold_hit && !done && owner_req;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            grant_q   <= '0;
            sel_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule : mux16_rr_arbiter
